// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op and FSM encodings used by the datapath and its control decoder.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with HI/LO result registers.
// One shared shift/accumulate datapath serves both operation classes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e         st;
  op_e            op_q;
  logic [CW-1:0]  cnt;
  logic           neg_q;
  logic           sa_q;
  logic           bz_q;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  op_e              op_in;
  logic             sgn_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign op_in  = op_e'(op);
  assign sgn_in = is_signed(op_in);
  assign mag_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn_in && b[WIDTH-1]) ? -b : b;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  // Multiply shifts right through {acc_hi,acc_lo};
  // divide shifts left and keeps the remainder in acc_hi.
  always_comb begin
    sum    = {1'b0, acc_hi[WIDTH-1:0]}
           + (acc_lo[0] ? {1'b0, opnd} : '0);
    shl    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    diff   = shl - {1'b0, opnd};
    nxt_hi = '0;
    nxt_lo = '0;
    if (is_div(op_q)) begin
      if (!diff[WIDTH]) begin
        nxt_hi = diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shl;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = {1'b0, sum[WIDTH:1]};
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod     = {acc_hi[WIDTH-1:0], acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -acc_lo : acc_lo;
    rem_fix  = sa_q ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div(op_q)) begin
      res_hi = rem_fix;
      res_lo = bz_q ? '1 : quot_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= IDLE;
      op_q   <= OP_MULTU;
      cnt    <= '0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      bz_q   <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            op_q   <= op_in;
            neg_q  <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            sa_q   <= sgn_in & a[WIDTH-1];
            bz_q   <= (b == '0);
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
            cnt    <= '0;
            st     <= RUN;
          end else begin
            if (mthi) hi <= wd;
            if (mtlo) lo <= wd;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (cnt == CW'(WIDTH)) begin
            st <= FIX;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CW'(1);
          end
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin an operation.
REQ-005 SHALL have port op, input, 2, operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a, input, WIDTH, multiplicand or dividend, taken from the register file rd1 read data.
REQ-007 SHALL have port b, input, WIDTH, multiplier or divisor, taken from the register file rd2 read data.
REQ-008 SHALL have port mthi, input, 1, write wd into HI.
REQ-009 SHALL have port mtlo, input, 1, write wd into LO.
REQ-010 SHALL have port wd, input, WIDTH, MTHI/MTLO data.
REQ-011 SHALL have port busy, output, 1, operation in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when HI/LO hold a new result.
REQ-013 SHALL have port hi, output, WIDTH, HI register (product upper half or remainder).
REQ-014 SHALL have port lo, output, WIDTH, LO register (product lower half or quotient).

Function
REQ-015 SHALL implement states IDLE, RUN and FIX, registered.
- IDLE -> RUN on start.
- RUN -> FIX after exactly WIDTH iterations.
- FIX -> IDLE unconditionally.
REQ-016 SHALL, in IDLE with start=1, latch op and the magnitudes of a and b; magnitudes are taken for signed ops only.
REQ-017 SHALL, in RUN, perform one radix-2 iteration per cycle.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
- Iteration counter width is ceil(log2(WIDTH))+1.
REQ-018 SHALL, in FIX, apply sign correction and write the result into hi and lo.
- Signed multiply: negate the 2*WIDTH product if sign(a) XOR sign(b).
- Signed divide: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a).
REQ-019 SHALL update hi and lo and assert done for exactly one cycle, WIDTH+2 rising edges after the edge that sampled start.
REQ-020 SHALL hold busy high from the edge after start is sampled up to, but not including, the cycle in which done is high.
REQ-021 SHALL ignore start, mthi and mtlo while busy=1; no queueing.
REQ-022 SHALL handle divide by zero (b=0, DIVU or DIV) as follows:
- lo = all ones.
- hi = a unchanged.
- Same latency as a normal divide.
REQ-023 SHALL, for DIV with a=most-negative and b=-1, produce lo = most-negative and hi = 0; no exception.
REQ-024 SHALL, in IDLE, write wd to hi when mthi=1 and to lo when mtlo=1, on the next edge; both may occur in the same cycle.
REQ-025 SHALL give start priority over mthi/mtlo when they occur in the same IDLE cycle; the mthi/mtlo write is dropped.
REQ-026 SHALL hold hi and lo stable while RUN and FIX are in progress; they are not updated until the result write.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, force the following regardless of state, aborting any operation:
- state = IDLE.
- hi = 0, lo = 0.
- busy = 0, done = 0.
- counter = 0.
REQ-028 SHALL give reset priority over start, mthi and mtlo in the same cycle.

Structure
REQ-029 SHALL take the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV) and the state encoding from a shared package muldiv_pkg, which the control decoder also uses.
REQ-030 SHALL implement a single shared accumulator/shift datapath inside muldiv_unit; no sub-module is required.

Verification (WIDTH=32)
REQ-031 SHALL verify MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF:
- hi=0xFFFFFFFE, lo=0x00000001.
- done pulses at edge 34 after start.
- busy is high on edges 1..33.
REQ-032 SHALL verify signed multiply and divide:
- MULT a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL verify the divide boundary cases:
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x64, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-034 SHALL verify that inputs are ignored during an operation: start (new operands) and mthi (wd=0xDEADBEEF) pulsed at iteration 5 of a MULTU 3*5 -> hi=0, lo=15, exactly one done pulse.
REQ-035 SHALL verify reset mid-operation: reset pulsed at iteration 10 of a DIVU -> hi=lo=0, busy=0 and no done pulse afterwards.
REQ-036 SHALL verify the IDLE writes:
- mthi with wd=0x12345678 in IDLE -> hi=0x12345678 on the next edge.
- start and mtlo in the same cycle -> lo takes only the operation result.
